fb_write_arbiter: RTL

Single-port write arbiter and clear sequencer for the LED panel RGB framebuffer. Two independent requesters share the framebuffer's one pixel write port: the cursor/button logic and a pattern or animation generator. A built-in clear engine can sweep every pixel to black. The scan engine drives `i_hold` to freeze all writes while it must not see the framebuffer change.

---
 rtl/fb_write_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/fb_write_arbiter.sv
// Purpose : two-requester round-robin arbiter for the framebuffer pixel write port,
//           with a built-in clear engine that sweeps every pixel to black.
// Latency : 1 cycle from accept (valid && ready) to o_wr_en; clear emits 1 pixel/cycle.
// Backpressure: readies drop while i_hold, during a clear, on a clear start and in reset;
//           i_hold also pauses the clear sweep without losing its position.
//
// Ports:
//   i_clock, i_reset            single clock, synchronous active-high reset
//   i_reqN_valid/o_reqN_ready   per-requester handshake (ready is combinational)
//   i_reqN_x/_y/_rgb            requested pixel coordinate and {b,g,r} value
//   i_clear_start               one-cycle pulse, starts a full-frame clear from S_IDLE
//   i_hold                      freeze: no grants, clear sweep paused
//   o_clear_busy                clear sweep in progress
//   o_wr_en/_x/_y/_rgb          registered framebuffer write port
//   o_last_grant                index of the most recently granted requester
module fb_write_arbiter #(
    parameter int COLS        = 32,
    parameter int ROWS        = 16,
    parameter int COLOR_DEPTH = 1,
    // Bits needed to hold the largest column / row index (at least one bit).
    localparam int COL_BITS   = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int ROW_BITS   = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int PIX_BITS   = 3 * COLOR_DEPTH
) (
    input  logic                i_clock,
    input  logic                i_reset,

    input  logic                i_req0_valid,
    output logic                o_req0_ready,
    input  logic [COL_BITS-1:0] i_req0_x,
    input  logic [ROW_BITS-1:0] i_req0_y,
    input  logic [PIX_BITS-1:0] i_req0_rgb,

    input  logic                i_req1_valid,
    output logic                o_req1_ready,
    input  logic [COL_BITS-1:0] i_req1_x,
    input  logic [ROW_BITS-1:0] i_req1_y,
    input  logic [PIX_BITS-1:0] i_req1_rgb,

    input  logic                i_clear_start,
    input  logic                i_hold,
    output logic                o_clear_busy,

    output logic                o_wr_en,
    output logic [COL_BITS-1:0] o_wr_x,
    output logic [ROW_BITS-1:0] o_wr_y,
    output logic [PIX_BITS-1:0] o_wr_rgb,
    output logic                o_last_grant
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(COLS - 1);
    localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                state_q,      state_d;
    logic                  ptr_q,        ptr_d;        // requester favoured on a tie
    logic [COL_BITS-1:0]   clr_col_q,    clr_col_d;    // clear counter, column part
    logic [ROW_BITS-1:0]   clr_row_q,    clr_row_d;    // clear counter, row part
    logic                  busy_q,       busy_d;
    logic                  wr_en_q,      wr_en_d;
    logic [COL_BITS-1:0]   wr_x_q,       wr_x_d;
    logic [ROW_BITS-1:0]   wr_y_q,       wr_y_d;
    logic [PIX_BITS-1:0]   wr_rgb_q,     wr_rgb_d;
    logic                  last_grant_q, last_grant_d;

    // ------------------------------------------------------------------
    // Combinational readies
    // ------------------------------------------------------------------
    // Grants are only possible in S_IDLE with nothing else claiming the
    // port this cycle. A clear start wins over any simultaneous request.
    logic grant_window;
    logic clr_last_pixel;

    assign grant_window = (state_q == S_IDLE) && !i_hold && !i_clear_start && !i_reset;

    // On a tie the pointer decides; alone, a requester is always served.
    assign o_req0_ready = grant_window && i_req0_valid && (!i_req1_valid || (ptr_q == 1'b0));
    assign o_req1_ready = grant_window && i_req1_valid && (!i_req0_valid || (ptr_q == 1'b1));

    // The counter is kept as separate column/row fields so raster order
    // falls out without a divide when COLS is not a power of two.
    assign clr_last_pixel = (clr_col_q == LAST_COL) && (clr_row_q == LAST_ROW);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        clr_col_d    = clr_col_q;
        clr_row_d    = clr_row_q;
        busy_d       = busy_q;
        wr_en_d      = 1'b0;          // strobe is one cycle per pixel
        wr_x_d       = wr_x_q;        // write data holds between writes
        wr_y_d       = wr_y_q;
        wr_rgb_d     = wr_rgb_q;
        last_grant_d = last_grant_q;

        unique case (state_q)
            S_IDLE: begin
                if (!i_hold) begin
                    if (i_clear_start) begin
                        state_d   = S_CLEAR;
                        clr_col_d = '0;
                        clr_row_d = '0;
                        busy_d    = 1'b1;
                    end else if (o_req0_ready) begin
                        wr_en_d      = 1'b1;
                        wr_x_d       = i_req0_x;
                        wr_y_d       = i_req0_y;
                        wr_rgb_d     = i_req0_rgb;
                        last_grant_d = 1'b0;
                        ptr_d        = 1'b1;
                    end else if (o_req1_ready) begin
                        wr_en_d      = 1'b1;
                        wr_x_d       = i_req1_x;
                        wr_y_d       = i_req1_y;
                        wr_rgb_d     = i_req1_rgb;
                        last_grant_d = 1'b1;
                        ptr_d        = 1'b0;
                    end
                end
            end

            S_CLEAR: begin
                // Held cycles emit nothing and leave the counter in place,
                // so the sweep resumes exactly where it stopped.
                if (!i_hold) begin
                    wr_en_d  = 1'b1;
                    wr_x_d   = clr_col_q;
                    wr_y_d   = clr_row_q;
                    wr_rgb_d = '0;
                    if (clr_last_pixel) begin
                        // The final pixel's write becomes visible in the
                        // same cycle busy drops and requests are accepted.
                        state_d   = S_IDLE;
                        busy_d    = 1'b0;
                        clr_col_d = '0;
                        clr_row_d = '0;
                    end else if (clr_col_q == LAST_COL) begin
                        clr_col_d = '0;
                        clr_row_d = clr_row_q + 1'b1;
                    end else begin
                        clr_col_d = clr_col_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers (reset aborts a running sweep immediately)
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            ptr_q        <= 1'b0;
            clr_col_q    <= '0;
            clr_row_q    <= '0;
            busy_q       <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_x_q       <= '0;
            wr_y_q       <= '0;
            wr_rgb_q     <= '0;
            last_grant_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            clr_col_q    <= clr_col_d;
            clr_row_q    <= clr_row_d;
            busy_q       <= busy_d;
            wr_en_q      <= wr_en_d;
            wr_x_q       <= wr_x_d;
            wr_y_q       <= wr_y_d;
            wr_rgb_q     <= wr_rgb_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign o_clear_busy = busy_q;
    assign o_wr_en      = wr_en_q;
    assign o_wr_x       = wr_x_q;
    assign o_wr_y       = wr_y_q;
    assign o_wr_rgb     = wr_rgb_q;
    assign o_last_grant = last_grant_q;

endmodule
